// File: rtl/perf_sampler_if.sv
// Counter CSR access bus and sample stream shared by perf_sampler and its environment.
interface perf_sampler_if #(
  parameter int unsigned XLEN = 64
);
  logic [11:0]     addr_o;
  logic            we_o;
  logic [XLEN-1:0] data_o;
  logic [XLEN-1:0] data_i;
  logic            sample_valid_o;
  logic            sample_ready_i;
  logic [4:0]      sample_idx_o;
  logic [XLEN-1:0] sample_data_o;
  logic            sample_last_o;

  modport master (
    output addr_o, we_o, data_o,
    input  data_i,
    output sample_valid_o,
    input  sample_ready_i,
    output sample_idx_o, sample_data_o, sample_last_o
  );

  modport slave (
    input  addr_o, we_o, data_o,
    output data_i,
    input  sample_valid_o,
    output sample_ready_i,
    input  sample_idx_o, sample_data_o, sample_last_o
  );
endinterface

// File: rtl/perf_sampler.sv
// Periodically reads a masked set of hpm counters over a CSR bus and streams
// {index, value, last} samples through a small FIFO, optionally clearing each counter.
module perf_sampler #(
  parameter int unsigned NumCounters = 6,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned FifoDepth   = 4,
  parameter logic [11:0] BaseAddr    = 12'hB03
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_en_i,
  input  logic [31:0]            cfg_interval_i,
  input  logic [NumCounters-1:0] cfg_mask_i,
  input  logic                   cfg_clear_i,
  perf_sampler_if.master         bus,
  output logic                   busy_o,
  output logic [15:0]            stall_cnt_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdxW = 5;

  typedef enum logic [1:0] {IDLE, COUNT, READ, CLR} state_e;

  typedef struct packed {
    logic [IdxW-1:0] idx;
    logic [XLEN-1:0] data;
    logic            last;
  } sample_t;

  state_e          state, state_n;
  logic [31:0]     timer, timer_n;
  logic [IdxW-1:0] idx, idx_n;
  logic            push_c, pop_c, stall_c, full_c, last_c;
  logic [5:0]      first_c, higher_c;

  logic [PtrW-1:0] rd_ptr, wr_ptr, rd_n;
  logic [CntW-1:0] count, cnt_n;
  sample_t         mem [FifoDepth];
  sample_t         push_entry, head_n;

  // Lowest set mask bit at or above start; bit 5 of the result flags a hit.
  function automatic logic [5:0] next_set(input logic [NumCounters-1:0] mask,
                                          input logic [5:0] start);
    logic [5:0] res;
    res = '0;
    for (int i = int'(NumCounters) - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start))) res = {1'b1, 5'(i)};
    end
    return res;
  endfunction

  assign first_c    = next_set(cfg_mask_i, 6'd0);
  assign higher_c   = next_set(cfg_mask_i, 6'(idx) + 6'd1);
  assign last_c     = !higher_c[5];
  assign full_c     = (count == CntW'(FifoDepth));
  assign pop_c      = bus.sample_valid_o && bus.sample_ready_i;
  assign push_entry = '{idx: idx, data: bus.data_i, last: last_c};

  // Next-state and control decode.
  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    push_c  = 1'b0;
    stall_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_en_i) begin
          state_n = COUNT;
          timer_n = cfg_interval_i;
        end
      end
      COUNT: begin
        if (timer <= 32'd1) begin
          if (!first_c[5]) begin
            timer_n = cfg_interval_i;
          end else begin
            state_n = READ;
            idx_n   = first_c[IdxW-1:0];
          end
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      READ: begin
        if (!full_c) begin
          push_c = 1'b1;
          if (cfg_clear_i) begin
            state_n = CLR;
          end else if (last_c) begin
            state_n = COUNT;
            timer_n = cfg_interval_i;
          end else begin
            idx_n = higher_c[IdxW-1:0];
          end
        end else begin
          stall_c = 1'b1;
        end
      end
      CLR: begin
        if (last_c) begin
          state_n = COUNT;
          timer_n = cfg_interval_i;
        end else begin
          state_n = READ;
          idx_n   = higher_c[IdxW-1:0];
        end
      end
      default: state_n = IDLE;
    endcase
    // Disabling abandons the round; a CLR write already on the bus still lands.
    if (!cfg_en_i) begin
      state_n = IDLE;
      push_c  = 1'b0;
      stall_c = 1'b0;
    end
  end

  // FIFO bookkeeping; the head is re-registered from the post-update read pointer.
  always_comb begin
    cnt_n  = count + CntW'(push_c) - CntW'(pop_c);
    rd_n   = rd_ptr + PtrW'(pop_c);
    head_n = (push_c && (rd_n == wr_ptr)) ? push_entry : mem[rd_n];
  end

  always_ff @(posedge clk_i) begin
    if (push_c) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state              <= IDLE;
      timer              <= '0;
      idx                <= '0;
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      count              <= '0;
      bus.sample_valid_o <= 1'b0;
      bus.sample_idx_o   <= '0;
      bus.sample_data_o  <= '0;
      bus.sample_last_o  <= 1'b0;
      bus.addr_o         <= '0;
      bus.we_o           <= 1'b0;
      bus.data_o         <= '0;
      busy_o             <= 1'b0;
      stall_cnt_o        <= '0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      idx    <= idx_n;
      rd_ptr <= rd_n;
      wr_ptr <= wr_ptr + PtrW'(push_c);
      count  <= cnt_n;
      bus.sample_valid_o <= (cnt_n != '0);
      if (cnt_n != '0) begin
        bus.sample_idx_o  <= head_n.idx;
        bus.sample_data_o <= head_n.data;
        bus.sample_last_o <= head_n.last;
      end
      bus.addr_o <= ((state_n == READ) || (state_n == CLR)) ? BaseAddr + 12'(idx_n) : 12'h000;
      bus.we_o   <= (state_n == CLR);
      bus.data_o <= '0;
      busy_o     <= (state_n == READ) || (state_n == CLR);
      if (stall_c && (stall_cnt_o != 16'hFFFF)) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

endmodule

// File: doc/perf_sampler.md
PERF_SAMPLER -- requirements
Module: perf_sampler

Interface
REQ-001 Parameter NumCounters, default 6, number of hpm counters sampled, max 29.
REQ-002 Parameter XLEN, default 64, CSR data width.
REQ-003 Parameter FifoDepth, default 4, sample FIFO entries, power of two, at least 2.
REQ-004 Parameter BaseAddr, default 12'hB03, CSR address of counter index 0 (mhpmcounter3).
REQ-005 Ports: clock and reset.
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
REQ-006 Ports: configuration.
- cfg_en_i  in  1  sampling enable.
- cfg_interval_i  in  32  cycles spent in COUNT between rounds.
- cfg_mask_i  in  NumCounters  counters to sample.
- cfg_clear_i  in  1  zero each counter after it is read.
REQ-007 Ports: counter SRAM-like interface (initiator side).
- addr_o  out  12  CSR address.
- we_o  out  1  write enable.
- data_o  out  XLEN  write data.
- data_i  in  XLEN  combinational read data for addr_o.
REQ-008 Ports: sample stream.
- sample_valid_o  out  1  FIFO head valid.
- sample_ready_i  in  1  sink accepts head.
- sample_idx_o  out  5  counter index.
- sample_data_o  out  XLEN  counter value.
- sample_last_o  out  1  last sample of its round.
REQ-009 Ports: status.
- busy_o  out  1  high when state is READ or CLR.
- stall_cnt_o  out  16  cycles stalled on a full FIFO.

Function
REQ-010 FSM states: IDLE, COUNT, READ, CLR; reset state is IDLE.
REQ-011 IDLE:
- addr_o=0, we_o=0.
- when cfg_en_i=1, go to COUNT and load timer with cfg_interval_i.
REQ-012 COUNT timer:
- each cycle: timer<=1 -> leave COUNT; otherwise decrement timer.
- so interval 0 or 1 gives 1 cycle in COUNT; interval N>1 gives N cycles.
REQ-013 COUNT exit:
- cfg_mask_i==0 -> reload timer, stay in COUNT, emit nothing.
- otherwise -> READ with idx = lowest set mask bit.
REQ-014 cfg_mask_i is sampled each time the next index is chosen; mask changes take effect from the next index selection.
REQ-015 READ: addr_o=BaseAddr+idx, we_o=0, data_o=0.
REQ-016 READ push: if the FIFO is not full (registered count), push {idx, data_i, last} in that cycle. last=1 when no higher set mask bit exists.
REQ-017 READ after a push:
- cfg_clear_i=1 -> CLR.
- else if last -> COUNT, reload timer.
- else -> READ at the next set index.
REQ-018 READ with FIFO full:
- hold state and addr_o.
- increment stall_cnt_o, saturating at 16'hFFFF.
REQ-019 CLR:
- one cycle: we_o=1, addr_o=BaseAddr+idx, data_o=0.
- then next index (READ) or, if last, COUNT with timer reload.
REQ-020 cfg_en_i=0 in any state:
- next state is IDLE and the round is abandoned.
- FIFO contents and stall_cnt_o are kept.
- a CLR write in progress that cycle still completes.
REQ-021 FIFO:
- pop when sample_valid_o && sample_ready_i; outputs are the registered head.
- first sample_valid_o appears 1 cycle after its push.
REQ-022 Simultaneous push and pop: count unchanged. When full, a push is refused that cycle even if a pop occurs.
REQ-023 Output data is stable while sample_valid_o=1 and sample_ready_i=0.
REQ-024 Read/write pointers wrap modulo FifoDepth.

Reset
REQ-025 On rst_ni low, asynchronously:
- state=IDLE, timer=0, idx=0, FIFO empty.
- sample_valid_o=0, sample_idx_o=0, sample_data_o=0, sample_last_o=0.
- addr_o=0, we_o=0, data_o=0, busy_o=0, stall_cnt_o=0.
REQ-026 Reset mid-round discards all state; no write is issued after reset until a new round.

Verification
REQ-027 en=1, interval=3, mask=6'b000101, clear=0, ready=1, model counters 3→100, 5→200:
- 3 COUNT cycles, then READ 12'hB03, then READ 12'hB05.
- samples (0,100,last=0), (2,200,last=1).
- back in COUNT.
REQ-028 mask=0, interval=2 for 20 cycles -> no valid, addr_o never nonzero, busy_o=0.
REQ-029 clear=1, mask=6'b000001 -> READ 12'hB03, then CLR with we_o=1, data_o=0; sample value equals the pre-clear counter.
REQ-030 ready=0, mask=6'h3F, FifoDepth=4:
- 4 samples pushed, then READ holds at idx 4.
- stall_cnt_o increments each cycle.
- ready=1 -> remaining samples 4, 5 in order, last on idx 5.
REQ-031 en dropped during READ of idx 2 -> IDLE next cycle, queued samples still drain, no further addr_o activity.
REQ-032 rst_ni asserted with 3 samples queued -> all outputs zero immediately; sample_valid_o stays 0 after reset release with en=0.
